// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the MEM stage.
//   mem_state_t   : data-memory transaction FSM states
//   F3_*          : funct3 encodings for load/store size and sign
//   SZ_*          : access size carried in funct3[1:0]
//   is_misaligned : true when the address is not aligned to the access size
//   ld_extend     : selects a byte/halfword from a load word and extends it
package mem_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_RESP = 2'd2,
    M_DONE = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Loads and stores share the size encoding in the low two funct3 bits.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3[1:0] == SZ_H) && offset[0]) ||
           ((funct3[1:0] == SZ_W) && (offset != 2'b00));
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                            input logic [1:0]  offset,
                                            input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    ld_extend = {{24{b[7]}}, b};
      F3_H:    ld_extend = {{16{h[15]}}, h};
      F3_BU:   ld_extend = {24'h0, b};
      F3_HU:   ld_extend = {16'h0, h};
      F3_W:    ld_extend = word;
      default: ld_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_st_align.sv
// st_align: combinational store lane alignment.
//   size   in  : access size (funct3[1:0])
//   offset in  : byte address bits [1:0]
//   rs2    in  : store operand
//   web    out : active-low byte write enables
//   wdata  out : store data replicated across the lanes
module st_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [3:0]  web,
  output logic [31:0] wdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_web;
      logic [7:0] lane_data;

      always_comb begin
        lane_web  = 1'b1;
        lane_data = rs2[8*gi +: 8];
        case (size)
          SZ_B: begin
            lane_web  = (offset != LANE);
            lane_data = rs2[7:0];
          end
          SZ_H: begin
            // lanes 0/1 carry the low halfword copy, lanes 2/3 the high copy
            lane_web  = (offset[1] != LANE[1]);
            lane_data = rs2[8*(gi%2) +: 8];
          end
          SZ_W: lane_web = 1'b0;
          default: lane_web = 1'b1;
        endcase
      end

      assign web[gi]          = lane_web;
      assign wdata[8*gi +: 8] = lane_data;
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register plus data-memory access stage.
//   clk, rst (sync, active-low)
//   ex_*              : instruction fields from the execute stage
//   dm_req/addr/web/wdata, dm_ready/rvalid/rdata : data-memory port
//   mem_stall         : freezes the upstream pipeline while an access is open
//   MEM_rd_data_next, mem_rd_addr, mem_is_load   : forwarding / hazard info
//   WB_rd_data, wb_rd_addr, wb_reg_write         : write-back register
//   misalign, bus_err : one-cycle event pulses
module mem_stage
  import mem_pkg::*;
#(
  parameter int         TIMEOUT = 64,
  parameter logic [3:0] RST_WEB = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pctoreg,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_wb_pc,
  input  logic [2:0]  ex_funct3,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_web,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] MEM_rd_data_next,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_is_load,
  output logic [31:0] WB_rd_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  // EX/MEM register
  logic        m_valid_reg, m_reg_write_reg, m_mem_read_reg, m_mem_write_reg, m_wb_pc_reg;
  logic [31:0] m_alu_out_reg, m_rs2_reg, m_pctoreg_reg;
  logic [4:0]  m_rd_addr_reg;
  logic [2:0]  m_funct3_reg;

  // access FSM
  mem_state_t       state_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic [31:0]      ld_buf_reg;
  logic             bus_err_reg;

  // MEM/WB register
  logic [31:0] wb_rd_data_reg;
  logic [4:0]  wb_rd_addr_reg;
  logic        wb_reg_write_reg;

  logic [31:0] m_result, st_wdata;
  logic [3:0]  st_web;
  logic        m_is_mem, misaligned, pending, in_wait, tmo_hit, m_load;

  assign m_result   = m_wb_pc_reg ? m_pctoreg_reg : m_alu_out_reg;
  assign m_is_mem   = m_valid_reg & (m_mem_read_reg | m_mem_write_reg);
  assign m_load     = m_valid_reg & m_mem_read_reg;
  assign misaligned = m_is_mem & is_misaligned(m_funct3_reg, m_alu_out_reg[1:0]);
  assign pending    = m_is_mem & ~misaligned;
  assign in_wait    = (state_reg == M_REQ) || (state_reg == M_RESP);
  assign tmo_hit    = in_wait && (tmo_cnt_reg == TMO_LAST);

  st_align u_st_align (
    .size   (m_funct3_reg[1:0]),
    .offset (m_alu_out_reg[1:0]),
    .rs2    (m_rs2_reg),
    .web    (st_web),
    .wdata  (st_wdata)
  );

  // The request is raised straight from IDLE so a zero-wait memory can
  // accept it in the first MEM cycle; M regs are frozen, so it stays stable.
  assign dm_req    = pending & ((state_reg == M_IDLE) || (state_reg == M_REQ));
  assign dm_addr   = m_alu_out_reg;
  assign dm_web    = (dm_req & m_mem_write_reg) ? st_web : RST_WEB;
  assign dm_wdata  = st_wdata;
  assign mem_stall = pending & (state_reg != M_DONE);

  assign MEM_rd_data_next = m_result;
  assign mem_rd_addr      = m_rd_addr_reg;
  assign mem_is_load      = m_load;
  assign misalign         = misaligned;
  assign bus_err          = bus_err_reg;
  assign WB_rd_data       = wb_rd_data_reg;
  assign wb_rd_addr       = wb_rd_addr_reg;
  assign wb_reg_write     = wb_reg_write_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_reg     <= 1'b0;
      m_alu_out_reg   <= '0;
      m_rs2_reg       <= '0;
      m_pctoreg_reg   <= '0;
      m_rd_addr_reg   <= '0;
      m_reg_write_reg <= 1'b0;
      m_mem_read_reg  <= 1'b0;
      m_mem_write_reg <= 1'b0;
      m_wb_pc_reg     <= 1'b0;
      m_funct3_reg    <= '0;
    end else if (!mem_stall) begin
      m_valid_reg     <= ex_valid;
      m_alu_out_reg   <= ex_alu_out;
      m_rs2_reg       <= ex_rs2;
      m_pctoreg_reg   <= ex_pctoreg;
      m_rd_addr_reg   <= ex_rd_addr;
      m_reg_write_reg <= ex_reg_write;
      m_mem_read_reg  <= ex_mem_read;
      m_mem_write_reg <= ex_mem_write;
      m_wb_pc_reg     <= ex_wb_pc;
      m_funct3_reg    <= ex_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= M_IDLE;
      tmo_cnt_reg <= '0;
      ld_buf_reg  <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      tmo_cnt_reg <= (in_wait && !tmo_hit) ? tmo_cnt_reg + 1'b1 : '0;
      case (state_reg)
        M_IDLE: begin
          if (pending) begin
            if (dm_ready) state_reg <= m_mem_read_reg ? M_RESP : M_DONE;
            else          state_reg <= M_REQ;
          end
        end
        M_REQ: begin
          if (tmo_hit) begin
            state_reg   <= M_DONE;
            bus_err_reg <= 1'b1;
            ld_buf_reg  <= '0;
          end else if (dm_ready) begin
            state_reg <= m_mem_read_reg ? M_RESP : M_DONE;
          end
        end
        M_RESP: begin
          if (tmo_hit) begin
            state_reg   <= M_DONE;
            bus_err_reg <= 1'b1;
            ld_buf_reg  <= '0;
          end else if (dm_rvalid) begin
            state_reg  <= M_DONE;
            ld_buf_reg <= dm_rdata;
          end
        end
        M_DONE:  state_reg <= M_IDLE;
        default: state_reg <= M_IDLE;
      endcase
    end
  end

  // bus_err_reg is high exactly during the DONE cycle of an aborted access,
  // which is the cycle the WB register samples this instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_rd_data_reg   <= '0;
      wb_rd_addr_reg   <= '0;
      wb_reg_write_reg <= 1'b0;
    end else if (!mem_stall) begin
      wb_rd_data_reg   <= m_load ? ld_extend(ld_buf_reg, m_alu_out_reg[1:0], m_funct3_reg)
                                 : m_result;
      wb_rd_addr_reg   <= m_rd_addr_reg;
      wb_reg_write_reg <= m_valid_reg & m_reg_write_reg & ~misaligned & ~bus_err_reg &
                          (m_rd_addr_reg != 5'd0);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_wb_pc;
  logic [31:0] ex_alu_out, ex_rs2, ex_pctoreg;
  logic [4:0]  ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic        dm_req, dm_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_web;
  logic        mem_stall, mem_is_load, wb_reg_write, misalign, bus_err;
  logic [31:0] MEM_rd_data_next, WB_rd_data;
  logic [4:0]  mem_rd_addr, wb_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT), .RST_WEB(4'hF)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .ex_pctoreg(ex_pctoreg),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_pc(ex_wb_pc), .ex_funct3(ex_funct3),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_web(dm_web), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .MEM_rd_data_next(MEM_rd_data_next), .mem_rd_addr(mem_rd_addr),
    .mem_is_load(mem_is_load), .WB_rd_data(WB_rd_data), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write(wb_reg_write), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [31:0] alu, rs2, pc, rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw, wbpc;
    logic [2:0]  f3;
    int          dly;   // dm_req cycles before dm_ready
    int          gap;   // extra cycles between acceptance+1 and dm_rvalid
  } instr_t;

  typedef struct packed {
    int          stalls, reqs, mis, berr;
    logic        unstable, hung;
    logic [3:0]  web;
    logic [31:0] wdata, addr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fwd;
    logic [4:0]  mrd;
    logic        isld;
  } obs_t;

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                                input int dly, input int gap, input logic [31:0] rdata);
    instr_t i;
    i = '0;
    i.alu = alu; i.rs2 = rs2; i.rd = rd; i.rw = rw; i.mr = mr; i.mw = mw;
    i.f3 = f3; i.dly = dly; i.gap = gap; i.rdata = rdata;
    return i;
  endfunction

  // Load extraction from arithmetic: shift the wanted bytes down, mask, sign-fill.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] v;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // Transaction-level expectation: stall length, events, lanes and WB result.
  function automatic obs_t ref_model(input instr_t i);
    obs_t        e;
    int          size, off, nw;
    logic        mis, pend, tmo;
    logic [3:0]  lanes;
    logic [31:0] result;
    e      = '0;
    size   = int'(i.f3) % 4;
    off    = int'(i.alu % 32'd4);
    mis    = (i.mr || i.mw) && ((size == 1 && off % 2 == 1) || (size == 2 && off != 0));
    pend   = (i.mr || i.mw) && !mis;
    nw     = i.dly + (i.mr ? i.gap + 1 : 0);
    tmo    = pend && (nw >= TIMEOUT);
    e.stalls = !pend ? 0 : (tmo ? TIMEOUT + 1 : nw + 1);
    e.reqs   = !pend ? 0 : ((i.dly < TIMEOUT) ? i.dly : TIMEOUT) + 1;
    e.mis    = mis ? 1 : 0;
    e.berr   = tmo ? 1 : 0;
    e.addr   = i.alu;
    if (i.mw) begin
      lanes = (size == 0) ? 4'b0001 : (size == 1) ? 4'b0011 : 4'b1111;
      e.web = ~(lanes << off);
      e.wdata = (size == 0) ? {24'h0, i.rs2[7:0]} * 32'h01010101 :
                (size == 1) ? {16'h0, i.rs2[15:0]} * 32'h00010001 : i.rs2;
    end else begin
      e.web = 4'hF;
    end
    result    = i.wbpc ? i.pc : i.alu;
    e.fwd     = result;
    e.mrd     = i.rd;
    e.isld    = i.mr;
    e.wb_we   = i.rw && (i.rd != 5'd0) && !mis && !tmo;
    e.wb_rd   = i.rd;
    e.wb_data = i.mr ? (tmo ? 32'h0 : ref_load(i.rdata, off, i.f3)) : result;
    return e;
  endfunction

  // Issues one instruction followed by a bubble, plays the memory side, and
  // records what the DUT did until the instruction lands in WB.
  task automatic run_instr(input instr_t in, output obs_t o);
    int cyc, rcnt, acc_cyc;
    bit acc, done;
    o = '0;
    ex_valid = 1'b1; ex_alu_out = in.alu; ex_rs2 = in.rs2; ex_pctoreg = in.pc;
    ex_rd_addr = in.rd; ex_reg_write = in.rw; ex_mem_read = in.mr; ex_mem_write = in.mw;
    ex_wb_pc = in.wbpc; ex_funct3 = in.f3;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_alu_out = $urandom; ex_rs2 = $urandom; ex_pctoreg = $urandom;
    ex_rd_addr = 5'($urandom); ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    o.fwd = MEM_rd_data_next; o.mrd = mem_rd_addr; o.isld = mem_is_load;
    acc = 0; done = 0; rcnt = 0; acc_cyc = 0;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      if (mem_stall) o.stalls++;
      if (misalign)  o.mis++;
      if (bus_err)   o.berr++;
      if (dm_req) begin
        if (rcnt == 0) begin
          o.web = dm_web; o.wdata = dm_wdata; o.addr = dm_addr;
        end else if ({dm_web, dm_wdata, dm_addr} !== {o.web, o.wdata, o.addr}) begin
          o.unstable = 1'b1;
        end
        o.reqs++;
        if (!acc && rcnt == in.dly) begin dm_ready = 1'b1; acc = 1; acc_cyc = cyc; end
        rcnt++;
      end
      if (acc && in.mr && cyc == acc_cyc + 1 + in.gap) begin
        dm_rvalid = 1'b1; dm_rdata = in.rdata;
      end
      if (!mem_stall) done = 1;
    end
    o.hung = !done;
    @(posedge clk); #1;
    dm_ready = 1'b0; dm_rvalid = 1'b0;
    o.wb_we = wb_reg_write; o.wb_rd = wb_rd_addr; o.wb_data = WB_rd_data;
    $display("[TB] txn %s addr=%08h f3=%0d rd=%0d stalls=%0d reqs=%0d mis=%0d berr=%0d wb_we=%0b wb_data=%08h",
             in.mr ? "LD " : (in.mw ? "ST " : "ALU"), in.alu, in.f3, in.rd, o.stalls, o.reqs,
             o.mis, o.berr, o.wb_we, o.wb_data);
  endtask

  task automatic test_reset();
    rst = 1'b0; ex_valid = 0; ex_alu_out = 0; ex_rs2 = 0; ex_pctoreg = 0; ex_rd_addr = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_wb_pc = 0; ex_funct3 = 0;
    dm_ready = 0; dm_rvalid = 0; dm_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dm_req, mem_stall, misalign, bus_err, wb_reg_write, mem_is_load} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %06b want 000000",
                         {dm_req, mem_stall, misalign, bus_err, wb_reg_write, mem_is_load});
    end
    n_tests++;
    if (dm_web !== 4'hF) begin n_fail++; $display("FAIL reset_web: got %h want f", dm_web); end
    n_tests++;
    if ({WB_rd_data, wb_rd_addr, MEM_rd_data_next, dm_addr, dm_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: wb=%08h rd=%0d fwd=%08h addr=%08h wdata=%08h want all 0",
                         WB_rd_data, wb_rd_addr, MEM_rd_data_next, dm_addr, dm_wdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    obs_t o;
    run_instr(mk(32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'd0, 0, 0, 32'h0), o);
    n_tests++;
    if (o.fwd !== 32'h1234) begin n_fail++; $display("FAIL alu_fwd: got %08h want 00001234", o.fwd); end
    n_tests++;
    if (o.wb_data !== 32'h1234 || o.wb_we !== 1'b1 || o.wb_rd !== 5'd5) begin
      n_fail++; $display("FAIL alu_wb: got data=%08h we=%0b rd=%0d want 00001234/1/5", o.wb_data, o.wb_we, o.wb_rd);
    end
    n_tests++;
    if (o.stalls !== 0) begin n_fail++; $display("FAIL alu_stall: got %0d want 0", o.stalls); end
  endtask

  task automatic test_sb();
    obs_t o;
    run_instr(mk(32'h103, 32'hAABBCCDD, 5'd0, 0, 0, 1, 3'd0, 0, 0, 32'h0), o);
    n_tests++;
    if (o.web !== 4'b0111 || o.wdata !== 32'hDDDDDDDD || o.addr !== 32'h103) begin
      n_fail++; $display("FAIL sb_lanes: got web=%b wdata=%08h addr=%08h want 0111/dddddddd/00000103",
                         o.web, o.wdata, o.addr);
    end
    n_tests++;
    if (o.stalls !== 1 || o.wb_we !== 1'b0) begin
      n_fail++; $display("FAIL sb_stall: got stalls=%0d we=%0b want 1/0", o.stalls, o.wb_we);
    end
  endtask

  task automatic test_loads();
    obs_t o;
    run_instr(mk(32'h101, 32'h0, 5'd7, 1, 1, 0, 3'd0, 2, 0, 32'h000080FF), o);
    n_tests++;
    if (o.wb_data !== 32'hFFFFFF80 || o.wb_we !== 1'b1) begin
      n_fail++; $display("FAIL lb_data: got %08h we=%0b want ffffff80/1", o.wb_data, o.wb_we);
    end
    n_tests++;
    if (o.stalls !== 4 || o.web !== 4'hF || o.isld !== 1'b1) begin
      n_fail++; $display("FAIL lb_stall: got stalls=%0d web=%h isld=%0b want 4/f/1", o.stalls, o.web, o.isld);
    end
    run_instr(mk(32'h102, 32'h0, 5'd8, 1, 1, 0, 3'd5, 2, 0, 32'h80010000), o);
    n_tests++;
    if (o.wb_data !== 32'h00008001 || o.wb_we !== 1'b1) begin
      n_fail++; $display("FAIL lhu_data: got %08h we=%0b want 00008001/1", o.wb_data, o.wb_we);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_instr(mk(32'h102, 32'h0, 5'd9, 1, 1, 0, 3'd2, 0, 0, 32'h12345678), o);
    n_tests++;
    if (o.mis !== 1 || o.reqs !== 0) begin
      n_fail++; $display("FAIL misalign_pulse: got mis=%0d reqs=%0d want 1/0", o.mis, o.reqs);
    end
    n_tests++;
    if (o.wb_we !== 1'b0 || o.stalls !== 0) begin
      n_fail++; $display("FAIL misalign_wb: got we=%0b stalls=%0d want 0/0", o.wb_we, o.stalls);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_instr(mk(32'h200, 32'h0, 5'd4, 1, 1, 0, 3'd2, 100000, 0, 32'h0), o);
    n_tests++;
    if (o.berr !== 1 || o.stalls !== TIMEOUT + 1 || o.hung !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err: got berr=%0d stalls=%0d hung=%0b want 1/%0d/0",
                         o.berr, o.stalls, o.hung, TIMEOUT + 1);
    end
    n_tests++;
    if (o.wb_we !== 1'b0) begin n_fail++; $display("FAIL timeout_wb: got we=%0b want 0", o.wb_we); end
    run_instr(mk(32'hCAFE, 32'h0, 5'd6, 1, 0, 0, 3'd0, 0, 0, 32'h0), o);
    n_tests++;
    if (o.wb_we !== 1'b1 || o.wb_data !== 32'hCAFE || o.berr !== 0) begin
      n_fail++; $display("FAIL timeout_resume: got we=%0b data=%08h berr=%0d want 1/0000cafe/0",
                         o.wb_we, o.wb_data, o.berr);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    instr_t i;
    ex_valid = 1; ex_alu_out = 32'h300; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'd2;
    ex_reg_write = 1; ex_rd_addr = 5'd3; ex_wb_pc = 0;
    @(posedge clk); #1;
    ex_valid = 0;
    dm_ready = 1'b1;
    @(posedge clk); #1;
    dm_ready = 1'b0;
    n_tests++;
    if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_resp: got stall=%0b req=%0b want 1/0", mem_stall, dm_req);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_tests++;
    if (dm_req !== 1'b0 || dm_web !== 4'hF || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_port: got req=%0b web=%h stall=%0b want 0/f/0", dm_req, dm_web, mem_stall);
    end
    n_tests++;
    if (WB_rd_data !== 32'h0 || wb_rd_addr !== 5'd0 || wb_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_wb: got data=%08h rd=%0d we=%0b want 0/0/0", WB_rd_data, wb_rd_addr, wb_reg_write);
    end
    i = mk(32'h400, 32'h0, 5'd10, 1, 1, 0, 3'd1, 0, 0, 32'h0000F00D);
    run_instr(i, o);
    e = ref_model(i);
    n_tests++;
    if (o.wb_data !== e.wb_data || o.wb_we !== e.wb_we || o.stalls !== e.stalls) begin
      n_fail++; $display("FAIL mid_recover: got data=%08h we=%0b stalls=%0d want %08h/%0b/%0d",
                         o.wb_data, o.wb_we, o.stalls, e.wb_data, e.wb_we, e.stalls);
    end
  endtask

  task automatic test_random();
    obs_t   o, e;
    instr_t i;
    int     kind;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      i = mk($urandom, $urandom, 5'($urandom), 0, 0, 0, 3'd0, $urandom_range(0, 4),
             $urandom_range(0, 3), $urandom);
      i.pc = $urandom;
      if (kind == 0) begin
        i.rw = ($urandom_range(0, 7) != 0); i.wbpc = 1'($urandom);
        i.f3 = 3'($urandom);
      end else if (kind == 1) begin
        i.mr = 1; i.rw = 1;
        case ($urandom_range(0, 4))
          0: i.f3 = 3'd0; 1: i.f3 = 3'd1; 2: i.f3 = 3'd2; 3: i.f3 = 3'd4; default: i.f3 = 3'd5;
        endcase
      end else begin
        i.mw = 1; i.f3 = 3'($urandom_range(0, 2));
      end
      if (kind != 0 && $urandom_range(0, 3) != 0) begin
        if (i.f3 % 4 == 1) i.alu = i.alu & ~32'd1;
        if (i.f3 % 4 == 2) i.alu = i.alu & ~32'd3;
      end
      run_instr(i, o);
      e = ref_model(i);
      n_tests++;
      if (o.hung || o.stalls !== e.stalls || o.reqs !== e.reqs || o.unstable) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got stalls=%0d reqs=%0d unstable=%0b hung=%0b want %0d/%0d/0/0",
                           n, o.stalls, o.reqs, o.unstable, o.hung, e.stalls, e.reqs);
      end
      n_tests++;
      if (o.mis !== e.mis || o.berr !== e.berr) begin
        n_fail++; $display("FAIL rnd_events[%0d]: got mis=%0d berr=%0d want %0d/%0d", n, o.mis, o.berr, e.mis, e.berr);
      end
      n_tests++;
      if (o.fwd !== e.fwd || o.mrd !== e.mrd || o.isld !== e.isld) begin
        n_fail++; $display("FAIL rnd_fwd[%0d]: got %08h/%0d/%0b want %08h/%0d/%0b",
                           n, o.fwd, o.mrd, o.isld, e.fwd, e.mrd, e.isld);
      end
      n_tests++;
      if (o.wb_we !== e.wb_we || (e.wb_we && (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd))) begin
        n_fail++; $display("FAIL rnd_wb[%0d]: got we=%0b data=%08h rd=%0d want %0b/%08h/%0d",
                           n, o.wb_we, o.wb_data, o.wb_rd, e.wb_we, e.wb_data, e.wb_rd);
      end
      if (e.reqs > 0) begin
        n_tests++;
        if (o.web !== e.web || o.addr !== e.addr || (i.mw && o.wdata !== e.wdata)) begin
          n_fail++; $display("FAIL rnd_port[%0d]: got web=%b addr=%08h wdata=%08h want %b/%08h/%08h",
                             n, o.web, o.addr, o.wdata, e.web, e.addr, e.wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sb();
    test_loads();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access stage. It sits directly downstream of the execute ALU.
- It latches the ALU result, the forwarded store operand, the PC-to-reg value and the destination/control fields.
- It runs a request/response transaction on the data-memory port, aligns store data, and sign/zero-extends load data.
- It produces the MEM-stage forwarding value and the registered write-back result, and stalls the upstream pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 64: maximum cycles an access may spend in M_REQ or M_RESP before it is aborted with bus_err.
- RST_WEB, 4'hF: reset and idle value of dm_web (all byte writes disabled).

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-low.
- ex_valid  input  1  instruction present in EX.
- ex_alu_out  input  32  ALU result; this is the address for loads and stores.
- ex_rs2  input  32  forwarded rs2, used as store data.
- ex_pctoreg  input  32  PC+4 or PC+imm.
- ex_rd_addr  input  5  destination register.
- ex_reg_write  input  1  writes rd.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store.
- ex_wb_pc  input  1  select ex_pctoreg instead of ex_alu_out as the result.
- ex_funct3  input  3  access size/sign.
- dm_req  output  1  access request.
- dm_addr  output  32  byte address.
- dm_web  output  4  active-low byte write enables.
- dm_wdata  output  32  lane-aligned store data.
- dm_ready  input  1  request accepted.
- dm_rvalid  input  1  load data valid.
- dm_rdata  input  32  load word.
- mem_stall  output  1  freeze PC, IF/ID and ID/EX.
- MEM_rd_data_next  output  32  forwarding value from MEM (non-load instructions only).
- mem_rd_addr  output  5  rd in MEM, for hazard detection.
- mem_is_load  output  1  a load is in MEM.
- WB_rd_data  output  32  write-back data.
- wb_rd_addr  output  5  write-back rd.
- wb_reg_write  output  1  write-back enable.
- misalign  output  1  one-cycle pulse on a misaligned access.
- bus_err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst=0 at a clk edge): all registers and outputs are 0, dm_web=RST_WEB, FSM=M_IDLE, timeout counter=0.
- EX/MEM register: loads all ex_* fields on each edge where mem_stall=0. It holds while mem_stall=1.
- M_result = M_wb_pc ? M_pctoreg : M_alu_out.
- MEM_rd_data_next = M_result, combinational.
- mem_rd_addr = M_rd_addr.
- mem_is_load = M_valid & M_mem_read.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. A misaligned access issues no request, suppresses the rd write, and pulses misalign in the cycle it reaches MEM.
- pending = M_valid & (M_mem_read | M_mem_write) & !misaligned.
- mem_stall = pending & (state != M_DONE).
- FSM transitions:
  - M_IDLE: dm_req = pending. If pending & dm_ready: go to M_DONE for a store, M_RESP for a load. If pending & !dm_ready: go to M_REQ.
  - M_REQ: hold dm_req, dm_addr, dm_web and dm_wdata stable until dm_ready. Then go to M_DONE (store) or M_RESP (load).
  - M_RESP: on dm_rvalid, latch dm_rdata into the load buffer and go to M_DONE. dm_rvalid in the same cycle as dm_ready is not legal; the bench never drives it.
  - M_DONE: stall deasserts and the pipeline advances. Next state is M_IDLE.
- Timeout counter: increments in M_REQ and M_RESP and clears elsewhere. When count == TIMEOUT-1, go to M_DONE, pulse bus_err, force the load buffer to 0, and suppress the rd write.
- dm_addr = M_alu_out.
- Stores:
  - SB: dm_web = ~(4'b0001 << addr[1:0]), data byte replicated to all 4 lanes.
  - SH: dm_web = addr[1] ? 4'b0011 : 4'b1100, halfword replicated.
  - SW: dm_web = 4'b0000.
  - Loads and idle: dm_web = 4'hF.
- Loads: pick the byte or halfword by addr[1:0] from the buffered word.
  - funct3 0 = LB, 1 = LH: sign-extend.
  - funct3 4 = LBU, 5 = LHU: zero-extend.
  - funct3 2 = LW: full word.
- WB register, updated on each edge where mem_stall=0:
  - WB_rd_data = load ? extended data : M_result.
  - wb_rd_addr = M_rd_addr.
  - wb_reg_write = M_valid & M_reg_write & !misaligned & !timed_out & (M_rd_addr != 0).
- Latency: a non-memory instruction appears at WB one cycle after MEM. A load with zero-wait memory occupies MEM for 3 cycles (IDLE, RESP, DONE).
- Reset mid-transaction returns to M_IDLE immediately, drops dm_req, and discards the outstanding access.

Decomposition:
- Package mem_pkg holds:
  - enum mem_state_t {M_IDLE, M_REQ, M_RESP, M_DONE};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function ld_extend(word, offset, funct3).
- One sub-module, st_align, is combinational: funct3, addr[1:0] and rs2 produce dm_web and dm_wdata.

Test Plan:
- ALU op, rd=5, ex_alu_out=0x1234 -> MEM_rd_data_next=0x1234 next cycle; WB_rd_data=0x1234, wb_reg_write=1 one cycle later; mem_stall never 1.
- SB with addr=0x103, rs2=0xAABBCCDD, dm_ready=1 immediately -> dm_web=4'b0111, dm_wdata=0xDDDDDDDD, mem_stall=1 for exactly 1 cycle, wb_reg_write=0.
- LB at addr=0x101, dm_rdata=0x0000_80FF, dm_ready delayed 2 cycles, rvalid 1 cycle later -> WB_rd_data=0xFFFFFF80. Repeat as LHU at addr=0x102 with dm_rdata=0x8001_0000 -> WB_rd_data=0x00008001.
- LW at addr=0x102 -> misalign pulse, dm_req=0, wb_reg_write=0, no stall.
- Load with dm_ready held 0 and TIMEOUT=64 -> bus_err pulses after 64 cycles in M_REQ, wb_reg_write=0, pipeline resumes.
- rst=0 asserted while in M_RESP -> next cycle dm_req=0, dm_web=4'hF, mem_stall=0, all WB outputs 0.
